ras_ctrl: RTL and testbench

Front-end call/return predecoder driving the return address stack. Sits between fetch and decode, one instruction per cycle. Classifies each fetched RV32 instruction as call, return, coroutine swap or checkpointed branch, and generates the stack's push/pop/new_entry/is_branch strobes. Emits a registered packet with the predicted next PC, and throttles fetch so outstanding stack checkpoints never exceed the checkpoint capacity.

---
 rtl/core_pkg.sv | 28 ++
 rtl/ras_ctrl_if.sv | 38 +++
 rtl/ras_classify.sv | 45 ++++
 rtl/ras_ctrl.sv | 132 +++++++++++++
 tb/tb_ras_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared front-end definitions: RV32 control-flow opcodes, return-stack op classes
// and the link-register test used by the call/return predecoder.
package core_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    NONE,
    CALL,
    RET,
    SWAP,
    JALR_PLAIN,
    BR
  } ras_op_t;

  typedef enum logic {
    IDLE,
    SWAP_PUSH
  } ras_state_t;

  // x1 is always a link register; x5 joins it when the alternate link is enabled.
  function automatic logic is_link(input logic [4:0] r, input logic alt_link);
    return (r == 5'd1) | (alt_link & (r == 5'd5));
  endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch-side, decode-side and return-stack signals of the call/return predecoder.
// master drives the predecoder inputs (fetch, backend, stack); slave is ras_ctrl.
interface ras_ctrl_if;

  logic        must_flush;
  logic        branch_resolved;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_entry;
  logic        ras_is_branch;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;

  modport master (
    output must_flush, branch_resolved, in_valid, in_pc, in_instr,
           ras_top, ras_empty, out_ready,
    input  in_ready, ras_push, ras_pop, ras_new_entry, ras_is_branch,
           out_valid, out_pc, out_instr, out_pred_taken, out_pred_pc
  );

  modport slave (
    input  must_flush, branch_resolved, in_valid, in_pc, in_instr,
           ras_top, ras_empty, out_ready,
    output in_ready, ras_push, ras_pop, ras_new_entry, ras_is_branch,
           out_valid, out_pc, out_instr, out_pred_taken, out_pred_pc
  );

endinterface

// File: rtl/ras_classify.sv
// Combinational classifier: maps an instruction's opcode/rd/rs1 to its return-stack
// op and flags the classes that take a stack checkpoint (every JALR and branch).
module ras_classify
  import core_pkg::*;
#(
  parameter bit ALT_LINK = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output ras_op_t    op,
  output logic       is_ckpt
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link(rd, ALT_LINK);
  assign rs1_link = is_link(rs1, ALT_LINK);

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op      = NONE;
    is_ckpt = 1'b0;
    case (opcode)
      OP_JAL: begin
        if (rd_link) op = CALL;
      end
      OP_JALR: begin
        is_ckpt = 1'b1;
        if (rd_link && rs1_link) op = (rd == rs1) ? CALL : SWAP;
        else if (rd_link)        op = CALL;
        else if (rs1_link)       op = RET;
        else                     op = JALR_PLAIN;
      end
      OP_BRANCH: begin
        is_ckpt = 1'b1;
        op      = BR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ras_ctrl.sv
// Call/return predecoder between fetch and decode: drives return-stack strobes,
// registers a predicted-next-PC packet, and throttles fetch on checkpoint capacity.
module ras_ctrl
  import core_pkg::*;
#(
  parameter int CKPT_DEPTH = 4,
  parameter bit ALT_LINK   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  ras_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CKPT_DEPTH + 1);

  ras_state_t  state;
  logic [CW-1:0] ckpt_cnt;
  logic [31:0] swap_ret;

  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_instr_q;
  logic        out_pred_taken_q;
  logic [31:0] out_pred_pc_q;

  ras_op_t     op;
  logic        is_ckpt;
  logic        ckpt_stall;
  logic        in_ready;
  logic        accept;
  logic        ret_like;
  logic        pred_taken;
  logic [31:0] pc_plus4;
  logic        push, pop, is_branch;
  logic [31:0] new_entry;
  logic        cnt_inc, cnt_dec;

  ras_classify #(.ALT_LINK(ALT_LINK)) u_classify (
    .opcode  (bus.in_instr[6:0]),
    .rd      (bus.in_instr[11:7]),
    .rs1     (bus.in_instr[19:15]),
    .op      (op),
    .is_ckpt (is_ckpt)
  );

  assign pc_plus4   = bus.in_pc + 32'd4;
  assign ckpt_stall = is_ckpt & (ckpt_cnt == CW'(CKPT_DEPTH));
  assign in_ready   = (state == IDLE) & (~out_valid_q | bus.out_ready) & ~ckpt_stall;
  assign accept     = bus.in_valid & in_ready & ~bus.must_flush;
  assign ret_like   = (op == RET) | (op == SWAP);
  // The stack's top is only a usable target when the stack holds something.
  assign pred_taken = ret_like & ~bus.ras_empty;

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    is_branch = 1'b0;
    new_entry = 32'd0;
    if (!bus.must_flush) begin
      if (state == SWAP_PUSH) begin
        push      = 1'b1;
        new_entry = swap_ret;
      end else if (accept) begin
        push      = (op == CALL);
        new_entry = (op == CALL) ? pc_plus4 : 32'd0;
        pop       = pred_taken;
        is_branch = is_ckpt;
      end
    end
  end

  assign cnt_inc = is_branch;
  assign cnt_dec = bus.branch_resolved & (ckpt_cnt != '0);

  // NOTE: all sequential state updates use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ckpt_cnt         <= '0;
      swap_ret         <= 32'd0;
      out_valid_q      <= 1'b0;
      out_pc_q         <= 32'd0;
      out_instr_q      <= 32'd0;
      out_pred_taken_q <= 1'b0;
      out_pred_pc_q    <= 32'd0;
    end else if (bus.must_flush) begin
      state       <= IDLE;
      ckpt_cnt    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && op == SWAP) begin
            state    <= SWAP_PUSH;
            swap_ret <= pc_plus4;
          end
        end
        SWAP_PUSH: state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (accept) begin
        out_valid_q      <= 1'b1;
        out_pc_q         <= bus.in_pc;
        out_instr_q      <= bus.in_instr;
        out_pred_taken_q <= pred_taken;
        out_pred_pc_q    <= pred_taken ? bus.ras_top : pc_plus4;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case ({cnt_inc, cnt_dec})
        2'b10:   ckpt_cnt <= ckpt_cnt + CW'(1);
        2'b01:   ckpt_cnt <= ckpt_cnt - CW'(1);
        default: ckpt_cnt <= ckpt_cnt;
      endcase
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.ras_push       = push;
  assign bus.ras_pop        = pop;
  assign bus.ras_new_entry  = new_entry;
  assign bus.ras_is_branch  = is_branch;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_pc_q;
  assign bus.out_instr      = out_instr_q;
  assign bus.out_pred_taken = out_pred_taken_q;
  assign bus.out_pred_pc    = out_pred_pc_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: a table of single-instruction vectors plus
// hand-written sequences for swap, checkpoint throttling, backpressure, flush and reset.
module tb_ras_ctrl;

  localparam logic [31:0] I_NOP       = 32'h0000_0013;
  localparam logic [31:0] I_JAL_X1    = 32'h0000_00EF;
  localparam logic [31:0] I_JAL_X0    = 32'h0000_006F;
  localparam logic [31:0] I_JAL_X5    = 32'h0000_02EF;
  localparam logic [31:0] I_RET_X1    = 32'h0000_8067;
  localparam logic [31:0] I_SWAP      = 32'h0002_80E7;
  localparam logic [31:0] I_JALR_X1X1 = 32'h0000_80E7;
  localparam logic [31:0] I_JALR_X0X6 = 32'h0003_0067;
  localparam logic [31:0] I_JALR_X5X5 = 32'h0002_82E7;
  localparam logic [31:0] I_BEQ       = 32'h0000_0063;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ras_ctrl_if bus ();

  ras_ctrl #(.CKPT_DEPTH(4), .ALT_LINK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] top;
    logic        empty;
    logic        push;
    logic        pop;
    logic        br;
    logic [31:0] new_entry;
    logic        taken;
    logic [31:0] pred_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid        = 1'b0;
    bus.in_instr        = I_NOP;
    bus.in_pc           = 32'd0;
    bus.must_flush      = 1'b0;
    bus.branch_resolved = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    bus.ras_top   = 32'd0;
    bus.ras_empty = 1'b1;
    bus.out_ready = 1'b1;

    //                 instr        pc       top         empty push pop br  new_entry  taken pred_pc
    vecs[0] = '{I_JAL_X1,    32'h100, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104};
    vecs[1] = '{I_RET_X1,    32'h200, 32'h104,    1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   1'b1, 32'h104};
    vecs[2] = '{I_RET_X1,    32'h200, 32'h104,    1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h204};
    vecs[3] = '{I_JALR_X1X1, 32'h400, 32'h0,      1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 1'b0, 32'h404};
    vecs[4] = '{I_JALR_X0X6, 32'h500, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h504};
    vecs[5] = '{I_BEQ,       32'h600, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h604};
    vecs[6] = '{I_NOP,       32'h700, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h704};
    vecs[7] = '{I_JAL_X0,    32'h800, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h804};
    vecs[8] = '{I_JAL_X5,    32'h900, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 32'h904, 1'b0, 32'h904};
    vecs[9] = '{I_JALR_X5X5, 32'hA00, 32'h1234,   1'b0, 1'b1, 1'b0, 1'b1, 32'hA04, 1'b0, 32'hA04};

    // Reset state
    #12;
    check("rst_in_ready",     32'(bus.in_ready), 32'd1);
    check("rst_push",         32'(bus.ras_push), 32'd0);
    check("rst_pop",          32'(bus.ras_pop), 32'd0);
    check("rst_is_branch",    32'(bus.ras_is_branch), 32'd0);
    check("rst_new_entry",    bus.ras_new_entry, 32'd0);
    check("rst_out_valid",    32'(bus.out_valid), 32'd0);
    check("rst_out_pc",       bus.out_pc, 32'd0);
    check("rst_out_instr",    bus.out_instr, 32'd0);
    check("rst_pred_taken",   32'(bus.out_pred_taken), 32'd0);
    check("rst_pred_pc",      bus.out_pred_pc, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Table-driven single instructions
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_instr  = vecs[i].instr;
      bus.in_pc     = vecs[i].pc;
      bus.ras_top   = vecs[i].top;
      bus.ras_empty = vecs[i].empty;
      #2;
      check($sformatf("v%0d_in_ready", i),  32'(bus.in_ready), 32'd1);
      check($sformatf("v%0d_push", i),      32'(bus.ras_push), 32'(vecs[i].push));
      check($sformatf("v%0d_pop", i),       32'(bus.ras_pop), 32'(vecs[i].pop));
      check($sformatf("v%0d_is_branch", i), 32'(bus.ras_is_branch), 32'(vecs[i].br));
      if (vecs[i].push)
        check($sformatf("v%0d_new_entry", i), bus.ras_new_entry, vecs[i].new_entry);
      tick();
      bus.in_valid        = 1'b0;
      bus.in_instr        = I_NOP;
      bus.branch_resolved = vecs[i].br;
      #2;
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_out_pc", i),    bus.out_pc, vecs[i].pc);
      check($sformatf("v%0d_out_instr", i), bus.out_instr, vecs[i].instr);
      check($sformatf("v%0d_pred_taken", i), 32'(bus.out_pred_taken), 32'(vecs[i].taken));
      check($sformatf("v%0d_pred_pc", i),   bus.out_pred_pc, vecs[i].pred_pc);
      tick();
      bus.branch_resolved = 1'b0;
    end
    check("tbl_cnt_zero", 32'(dut.ckpt_cnt), 32'd0);

    // SWAP: pop + checkpoint in accept cycle, push one cycle later
    bus.in_valid  = 1'b1;
    bus.in_instr  = I_SWAP;
    bus.in_pc     = 32'h300;
    bus.ras_top   = 32'h104;
    bus.ras_empty = 1'b0;
    #2;
    check("swap_pop",      32'(bus.ras_pop), 32'd1);
    check("swap_is_br",    32'(bus.ras_is_branch), 32'd1);
    check("swap_push_n",   32'(bus.ras_push), 32'd0);
    tick();
    idle_inputs();
    bus.ras_top = 32'hDEAD_0000;
    #2;
    check("swap2_in_ready", 32'(bus.in_ready), 32'd0);
    check("swap2_push",     32'(bus.ras_push), 32'd1);
    check("swap2_new",      bus.ras_new_entry, 32'h304);
    check("swap2_pop",      32'(bus.ras_pop), 32'd0);
    check("swap2_pred_tk",  32'(bus.out_pred_taken), 32'd1);
    check("swap2_pred_pc",  bus.out_pred_pc, 32'h104);
    tick();
    #2;
    check("swap3_in_ready", 32'(bus.in_ready), 32'd1);
    check("swap3_push",     32'(bus.ras_push), 32'd0);
    bus.branch_resolved = 1'b1;
    tick();
    bus.branch_resolved = 1'b0;

    // Five back-to-back BEQs against four checkpoint slots
    bus.in_valid = 1'b1;
    bus.in_instr = I_BEQ;
    for (int k = 0; k < 4; k++) begin
      bus.in_pc = 32'h600 + 32'(4 * k);
      #2;
      check($sformatf("beq%0d_ready", k), 32'(bus.in_ready), 32'd1);
      check($sformatf("beq%0d_br", k),    32'(bus.ras_is_branch), 32'd1);
      tick();
    end
    bus.in_pc = 32'h610;
    #2;
    check("beq4_stall",    32'(bus.in_ready), 32'd0);
    check("beq4_br_n",     32'(bus.ras_is_branch), 32'd0);
    tick();
    #2;
    check("beq4_stall2",   32'(bus.in_ready), 32'd0);
    bus.branch_resolved = 1'b1;
    #1;
    check("beq4_stall_res", 32'(bus.in_ready), 32'd0);
    tick();
    bus.branch_resolved = 1'b0;
    #2;
    check("beq4_ready",    32'(bus.in_ready), 32'd1);
    check("beq4_br",       32'(bus.ras_is_branch), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_instr = I_NOP;
    #2;
    check("beq4_out_pc",   bus.out_pc, 32'h610);
    check("beq4_out_val",  32'(bus.out_valid), 32'd1);
    bus.branch_resolved = 1'b1;
    repeat (4) tick();
    bus.branch_resolved = 1'b0;
    check("beq_cnt_zero",  32'(dut.ckpt_cnt), 32'd0);

    // Decode backpressure: held packet, no acceptance, no strobes
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = I_JAL_X1;
    bus.in_pc     = 32'h100;
    #2;
    check("bp_accept_push", 32'(bus.ras_push), 32'd1);
    tick();
    bus.in_pc = 32'h110;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp%0d_push", k),     32'(bus.ras_push), 32'd0);
      check($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_out_pc", k),   bus.out_pc, 32'h100);
      tick();
    end
    bus.out_ready = 1'b1;
    #2;
    check("bp_rel_ready",  32'(bus.in_ready), 32'd1);
    check("bp_rel_new",    bus.ras_new_entry, 32'h114);
    tick();
    idle_inputs();
    #2;
    check("bp_rel_out_pc", bus.out_pc, 32'h110);
    tick();

    // Flush in an accept cycle suppresses strobes and the packet
    bus.in_valid   = 1'b1;
    bus.in_instr   = I_JAL_X1;
    bus.in_pc      = 32'hC00;
    bus.must_flush = 1'b1;
    #2;
    check("fl_acc_push",   32'(bus.ras_push), 32'd0);
    tick();
    idle_inputs();
    #2;
    check("fl_acc_valid",  32'(bus.out_valid), 32'd0);

    // Flush during SWAP_PUSH with three checkpoints outstanding
    bus.in_valid = 1'b1;
    bus.in_instr = I_BEQ;
    bus.in_pc    = 32'h10;
    tick();
    bus.in_pc    = 32'h14;
    tick();
    bus.in_instr  = I_SWAP;
    bus.in_pc     = 32'h18;
    bus.ras_top   = 32'h55;
    bus.ras_empty = 1'b0;
    #2;
    check("fs_pop",        32'(bus.ras_pop), 32'd1);
    tick();
    idle_inputs();
    bus.must_flush = 1'b1;
    #2;
    check("fs_cnt3",       32'(dut.ckpt_cnt), 32'd3);
    check("fs_push_n",     32'(bus.ras_push), 32'd0);
    tick();
    bus.must_flush = 1'b0;
    #2;
    check("fs_out_valid",  32'(bus.out_valid), 32'd0);
    check("fs_cnt0",       32'(dut.ckpt_cnt), 32'd0);
    check("fs_in_ready",   32'(bus.in_ready), 32'd1);
    check("fs_push_after", 32'(bus.ras_push), 32'd0);
    tick();

    // Asynchronous reset mid-stream, landing in SWAP_PUSH
    bus.in_valid  = 1'b1;
    bus.in_instr  = I_SWAP;
    bus.in_pc     = 32'h700;
    bus.ras_top   = 32'h99;
    bus.ras_empty = 1'b0;
    tick();
    idle_inputs();
    #2;
    check("ar_pre_push",   32'(bus.ras_push), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_push",       32'(bus.ras_push), 32'd0);
    check("ar_new_entry",  bus.ras_new_entry, 32'd0);
    check("ar_in_ready",   32'(bus.in_ready), 32'd1);
    check("ar_out_valid",  32'(bus.out_valid), 32'd0);
    check("ar_out_pc",     bus.out_pc, 32'd0);
    check("ar_out_instr",  bus.out_instr, 32'd0);
    check("ar_pred_taken", 32'(bus.out_pred_taken), 32'd0);
    check("ar_pred_pc",    bus.out_pred_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
